// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubbles, memory-wait freeze, branch redirect flush.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_memread,
    input  logic              br_taken,
    input  logic              imem_stall,
    input  logic              dmem_stall,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  cnt_loaduse,
    output logic [CNT_W-1:0]  cnt_memstall,
    output logic [CNT_W-1:0]  cnt_flush
);

    localparam int SCW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] TIMEOUT_C = SCW'(TIMEOUT);

    typedef enum logic {RUN, MWAIT} state_t;

    state_t         state_q, state_d;
    logic           pend_flush_q, pend_flush_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           stall_timeout_q, stall_timeout_d;

    logic mem_stall;
    logic flush_now;
    logic load_use;

    assign mem_stall = imem_stall | dmem_stall;
    assign flush_now = !mem_stall && (br_taken || pend_flush_q);
    assign load_use  = idex_memread && (idex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                        (id_use_rs2 && (id_rs2 == idex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            pend_flush_q    <= 1'b0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_flush_q    <= pend_flush_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    // A redirect seen during a freeze is remembered and replayed on the first free cycle.
    always_comb begin
        state_d         = state_q;
        pend_flush_d    = 1'b0;
        stall_cnt_d     = '0;
        stall_timeout_d = stall_timeout_q;
        case (state_q)
            RUN:   if (mem_stall)  state_d = MWAIT;
            MWAIT: if (!mem_stall) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (mem_stall) begin
            pend_flush_d = pend_flush_q | br_taken;
            if (state_q == RUN)
                stall_cnt_d = SCW'(1);
            else if (stall_cnt_q < TIMEOUT_C)
                stall_cnt_d = stall_cnt_q + SCW'(1);
            else
                stall_cnt_d = stall_cnt_q;
        end
        if (stall_cnt_d == TIMEOUT_C)
            stall_timeout_d = 1'b1;
    end

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exmem_we   = 1'b0;
            memwb_we   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exmem_we   = 1'b0;
            memwb_we   = 1'b0;
        end else if (flush_now) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign stall_timeout = stall_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_loaduse_q, cnt_loaduse_d;
    logic [CNT_W-1:0] cnt_memstall_q, cnt_memstall_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_loaduse_q  <= '0;
            cnt_memstall_q <= '0;
            cnt_flush_q    <= '0;
        end else begin
            cnt_loaduse_q  <= cnt_loaduse_d;
            cnt_memstall_q <= cnt_memstall_d;
            cnt_flush_q    <= cnt_flush_d;
        end
    end

    // Only the event that actually wins the priority is counted; counters stick at all-ones.
    always_comb begin
        cnt_loaduse_d  = cnt_loaduse_q;
        cnt_memstall_d = cnt_memstall_q;
        cnt_flush_d    = cnt_flush_q;
        if (mem_stall && (cnt_memstall_q != '1))
            cnt_memstall_d = cnt_memstall_q + CNT_W'(1);
        if (flush_now && (cnt_flush_q != '1))
            cnt_flush_d = cnt_flush_q + CNT_W'(1);
        if (!mem_stall && !flush_now && load_use && (cnt_loaduse_q != '1))
            cnt_loaduse_d = cnt_loaduse_q + CNT_W'(1);
    end

    assign cnt_loaduse  = cnt_loaduse_q;
    assign cnt_memstall = cnt_memstall_q;
    assign cnt_flush    = cnt_flush_q;
`else
    assign cnt_loaduse  = '0;
    assign cnt_memstall = '0;
    assign cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_hazard_stall_unit;

   localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Expected control word: {pc, ifid, idex, exmem, memwb we, ifid_flush, idex_flush, stall_timeout}
   localparam logic [7:0] NORM  = 8'b11111_00_0;
   localparam logic [7:0] FRZ   = 8'b00000_00_0;
   localparam logic [7:0] FLSH  = 8'b11111_11_0;
   localparam logic [7:0] LU    = 8'b00111_01_0;
   localparam logic [7:0] RSTV  = 8'b00000_11_0;
   localparam logic [7:0] TO    = 8'b00000_00_1;

   typedef struct {
      string      name;
      logic [7:0] ctrl;
      bit         chkCnt;
      int         lu;
      int         ms;
      int         fl;
   } expT;

   expT expQ[$];

   logic clock;
   logic reset;
   logic [4:0] idRs1, idRs2, idexRd;
   logic idUseRs1, idUseRs2, idexMemread, brTaken, imemStall, dmemStall;
   logic pcWe, ifidWe, idexWe, exmemWe, memwbWe, ifidFlush, idexFlush, stallTimeout;
   logic [CNT_W-1:0] cntLoaduse, cntMemstall, cntFlush;

   int compared = 0;
   int mismatched = 0;
   bit stimDone = 1'b0;

   hazard_stall_unit #(.REG_AW(5), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clock), .rst(reset),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
      .idex_rd(idexRd), .idex_memread(idexMemread), .br_taken(brTaken),
      .imem_stall(imemStall), .dmem_stall(dmemStall),
      .pc_we(pcWe), .ifid_we(ifidWe), .idex_we(idexWe), .exmem_we(exmemWe), .memwb_we(memwbWe),
      .ifid_flush(ifidFlush), .idex_flush(idexFlush), .stall_timeout(stallTimeout),
      .cnt_loaduse(cntLoaduse), .cnt_memstall(cntMemstall), .cnt_flush(cntFlush)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One call drives one cycle of inputs and queues what the outputs must be in that cycle.
   task automatic applyStimulus(input string name, input logic r,
                                input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic mr, input logic br,
                                input logic is, input logic ds, input logic [7:0] ctrl,
                                input bit chk, input int lu, input int ms, input int fl);
      expT e;
      reset = r;
      idRs1 = rs1; idUseRs1 = u1; idRs2 = rs2; idUseRs2 = u2;
      idexRd = rd; idexMemread = mr; brTaken = br;
      imemStall = is; dmemStall = ds;
      e.name = name; e.ctrl = ctrl; e.chkCnt = chk;
      e.lu = PERF ? lu : 0; e.ms = PERF ? ms : 0; e.fl = PERF ? fl : 0;
      expQ.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input expT e);
      logic [7:0] act;
      act = {pcWe, ifidWe, idexWe, exmemWe, memwbWe, ifidFlush, idexFlush, stallTimeout};
      compared++;
      if (act !== e.ctrl) begin
         mismatched++;
         $display("[TB] FAIL %s: ctrl actual=%b required=%b", e.name, act, e.ctrl);
      end
      if (e.chkCnt) begin
         compared++;
         if (cntLoaduse !== CNT_W'(e.lu) || cntMemstall !== CNT_W'(e.ms) || cntFlush !== CNT_W'(e.fl)) begin
            mismatched++;
            $display("[TB] FAIL %s_cnt: actual lu=%0d ms=%0d fl=%0d required lu=%0d ms=%0d fl=%0d",
                     e.name, cntLoaduse, cntMemstall, cntFlush, e.lu, e.ms, e.fl);
         end
      end
   endtask

   // Monitor: every falling edge the DUT presents one cycle's outputs.
   initial begin
      expT e;
      forever begin
         @(negedge clock);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      reset = 1'b1; idRs1 = '0; idRs2 = '0; idexRd = '0;
      idUseRs1 = 0; idUseRs2 = 0; idexMemread = 0; brTaken = 0; imemStall = 0; dmemStall = 0;
      @(posedge clock);
      #1;
      //             name          rst rs1 u1 rs2 u2 rd mr br is ds  ctrl        chk lu ms fl
      applyStimulus("reset",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV,       1, 0, 0, 0);
      applyStimulus("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,       1, 0, 0, 0);
      applyStimulus("lu_rs1",      0, 5, 1, 0, 0, 5, 1, 0, 0, 0, LU,         0, 0, 0, 0);
      applyStimulus("after_lu",    0, 5, 1, 0, 0, 0, 0, 0, 0, 0, NORM,       0, 0, 0, 0);
      applyStimulus("lu_x0",       0, 0, 1, 0, 0, 0, 1, 0, 0, 0, NORM,       0, 0, 0, 0);
      applyStimulus("lu_rs2_nouse",0, 3, 1, 5, 0, 5, 1, 0, 0, 0, NORM,       0, 0, 0, 0);
      applyStimulus("dstall1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,        0, 0, 0, 0);
      applyStimulus("dstall2_br",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,        0, 0, 0, 0);
      applyStimulus("dstall3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ,        0, 0, 0, 0);
      applyStimulus("pend_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH,       0, 0, 0, 0);
      applyStimulus("post_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,       1, 1, 3, 1);
      applyStimulus("lu_rs2",      0, 1, 0, 5, 1, 5, 1, 0, 0, 0, LU,         0, 0, 0, 0);
      applyStimulus("br_over_lu",  0, 5, 1, 0, 0, 5, 1, 1, 0, 0, FLSH,       0, 0, 0, 0);
      applyStimulus("post_br",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,       1, 2, 3, 2);
      applyStimulus("istall1",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,        0, 0, 0, 0);
      applyStimulus("istall2",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,        0, 0, 0, 0);
      applyStimulus("istall3",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,        0, 0, 0, 0);
      applyStimulus("istall4",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,        0, 0, 0, 0);
      applyStimulus("istall5_to",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ | TO,   0, 0, 0, 0);
      applyStimulus("istall6_lu",  0, 5, 1, 0, 0, 5, 1, 0, 1, 0, FRZ | TO,   0, 0, 0, 0);
      applyStimulus("to_sticky",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | TO,  0, 0, 0, 0);
      applyStimulus("to_sticky2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | TO,  1, 2, 9, 2);
      applyStimulus("stall_br",    0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ | TO,   0, 0, 0, 0);
      applyStimulus("rst_mid",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RSTV,       1, 0, 0, 0);
      applyStimulus("no_pend",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,       0, 0, 0, 0);
      applyStimulus("final",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,       1, 0, 0, 0);
      stimDone = 1'b1;
   end

   // Finish once the scoreboard drains, or flag it if it never does.
   initial begin
      wait (stimDone == 1'b1);
      repeat (3) @(posedge clock);
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: actual pending=%0d required=0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: actual=stuck required=finish");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
